// File: rtl/hub75_fb_writein_ring_pkg.sv
// Shared definitions for the HUB75 frame-buffer write-in ring.
// Holds geometry constants, derived address widths, the row descriptor
// layout, the drain FSM state encoding and the FB address/word helpers.
package hub75_fb_writein_ring_pkg;

    localparam int N_BANKS  = 2;
    localparam int N_ROWS   = 32;
    localparam int N_COLS   = 64;
    localparam int BITDEPTH = 24;
    localparam int FB_DW    = 16;
    localparam int FB_DC    = 2;
    localparam int N_LBUF   = 4;

    localparam int LOG_N_BANKS = $clog2(N_BANKS);
    localparam int LOG_N_ROWS  = $clog2(N_ROWS);
    localparam int LOG_N_COLS  = $clog2(N_COLS);
    localparam int LOG_FB_DC   = $clog2(FB_DC);
    localparam int LOG_N_LBUF  = $clog2(N_LBUF);

    localparam int FB_AW     = LOG_N_ROWS + LOG_N_COLS + LOG_N_BANKS + LOG_FB_DC;
    localparam int LBUF_AW   = LOG_N_LBUF + LOG_N_COLS;
    localparam int PIX_EXT_W = FB_DC * FB_DW;

    typedef struct packed {
        logic [LOG_N_BANKS-1:0] bank;
        logic [LOG_N_ROWS-1:0]  row;
        logic [LOG_N_COLS-1:0]  first;
        logic [LOG_N_COLS-1:0]  last;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RUN,
        ST_FLUSH
    } drain_state_t;

    function automatic logic [FB_AW-1:0] fb_pack(
        input logic [LOG_N_ROWS-1:0]  row,
        input logic [LOG_N_COLS-1:0]  col,
        input logic [LOG_N_BANKS-1:0] bank,
        input logic [LOG_FB_DC-1:0]   dc
    );
        return {row, col, bank, dc};
    endfunction

    // Word dc of the zero-extended pixel, least significant word first.
    function automatic logic [FB_DW-1:0] word_sel(
        input logic [PIX_EXT_W-1:0] px,
        input logic [LOG_FB_DC-1:0] dc
    );
        logic [FB_DW-1:0] w;
        w = '0;
        for (int i = 0; i < FB_DC; i++) begin
            if (dc == LOG_FB_DC'(i)) begin
                w = px[i*FB_DW +: FB_DW];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hub75_fb_writein_ring_descq.sv
// Descriptor queue: register FIFO of committed row descriptors, depth N_LBUF.
// Its write/read pointers double as the fill slot and drain slot of the line-buffer ring.
// Ports: clk, rst (async, active-high); push/push_desc enqueue; pop dequeue;
//        head = oldest descriptor; wp/rp = ring pointers; level = entries held.
// The caller guarantees push only when not full and pop only when not empty.
module hub75_fb_writein_ring_descq
    import hub75_fb_writein_ring_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  desc_t                 push_desc,
    input  logic                  pop,
    output desc_t                 head,
    output logic [LOG_N_LBUF-1:0] wp,
    output logic [LOG_N_LBUF-1:0] rp,
    output logic [LOG_N_LBUF:0]   level
);

    desc_t q [0:N_LBUF-1];

    always_ff @(posedge clk) begin
        if (push) begin
            q[wp] <= push_desc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign head = q[rp];

endmodule

// File: rtl/hub75_fb_writein_ring_lbuf.sv
// Line-buffer pixel store: N_LBUF rows of N_COLS pixels, addressed {slot, col}.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write port;
//        rd_addr/rd_data combinational read port (the caller registers the result).
module hub75_fb_writein_ring_lbuf #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hub75_fb_writein_ring.sv
// HUB75 frame-buffer write-in ring.
// Producers fill line-buffer slot wp pixel by pixel and commit it with a row
// descriptor; a drain engine copies each committed column span into the frame
// buffer through the shared arbiter, FB_DC words per pixel.
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_bank_addr/wr_row_addr  target bank/row of the row being committed
//   wr_col_first/wr_col_last  inclusive column span to copy
//   wr_row_store, wr_row_rdy  commit strobe / a free fill buffer exists
//   wr_data/wr_col_addr/wr_en pixel fill port
//   wr_err                    sticky: a commit was rejected
//   q_level                   committed rows not yet drained
//   ctrl_req/ctrl_gnt/ctrl_rel  FB arbiter handshake
//   fb_addr/fb_data/fb_wren   FB write port, addr = {row, col, bank, dc}
//
// Drain FSM
//   state    | meaning
//   ST_IDLE  | nothing to drain, or waiting one cycle after a release
//   ST_REQ   | ctrl_req high; on grant the first word is read and written
//   ST_RUN   | one line-buffer read and FB write per cycle
//   ST_FLUSH | final write + ctrl_rel on the outputs; descriptor popped
module hub75_fb_writein_ring
    import hub75_fb_writein_ring_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LOG_N_BANKS-1:0] wr_bank_addr,
    input  logic [LOG_N_ROWS-1:0]  wr_row_addr,
    input  logic [LOG_N_COLS-1:0]  wr_col_first,
    input  logic [LOG_N_COLS-1:0]  wr_col_last,
    input  logic                   wr_row_store,
    output logic                   wr_row_rdy,
    input  logic [BITDEPTH-1:0]    wr_data,
    input  logic [LOG_N_COLS-1:0]  wr_col_addr,
    input  logic                   wr_en,
    output logic                   wr_err,
    output logic [LOG_N_LBUF:0]    q_level,
    output logic                   ctrl_req,
    input  logic                   ctrl_gnt,
    output logic                   ctrl_rel,
    output logic [FB_AW-1:0]       fb_addr,
    output logic [FB_DW-1:0]       fb_data,
    output logic                   fb_wren
);

    drain_state_t          state;
    desc_t                 head;
    desc_t                 new_desc;
    logic [LOG_N_LBUF-1:0] wp;
    logic [LOG_N_LBUF-1:0] rp;
    logic                  store_ok;
    logic                  pop;
    logic [LOG_N_COLS-1:0] cnt_col;
    logic [LOG_FB_DC-1:0]  cnt_dc;
    logic                  is_last;
    logic [BITDEPTH-1:0]   rd_pix;
    logic [PIX_EXT_W-1:0]  pix_ext;
    logic [FB_DW-1:0]      rd_word;

    localparam logic [LOG_FB_DC-1:0] DC_MAX = LOG_FB_DC'(FB_DC - 1);

    // The fill slot is one more free slot on top of the queued rows, so the
    // ring is only full once all N_LBUF slots hold committed rows.
    assign wr_row_rdy = (q_level != (LOG_N_LBUF + 1)'(N_LBUF));
    assign store_ok   = wr_row_store && wr_row_rdy && (wr_col_first <= wr_col_last);
    assign pop        = (state == ST_FLUSH);

    assign new_desc = '{bank:  wr_bank_addr,
                        row:   wr_row_addr,
                        first: wr_col_first,
                        last:  wr_col_last};

    hub75_fb_writein_ring_descq u_descq (
        .clk       (clk),
        .rst       (rst),
        .push      (store_ok),
        .push_desc (new_desc),
        .pop       (pop),
        .head      (head),
        .wp        (wp),
        .rp        (rp),
        .level     (q_level)
    );

    // When the ring is full wp aliases the head slot being drained, so fill
    // writes are dropped until a slot frees up.
    hub75_fb_writein_ring_lbuf #(
        .ADDR_WIDTH (LBUF_AW),
        .DATA_WIDTH (BITDEPTH)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (wr_en && wr_row_rdy),
        .wr_addr ({wp, wr_col_addr}),
        .wr_data (wr_data),
        .rd_addr ({rp, cnt_col}),
        .rd_data (rd_pix)
    );

    assign pix_ext = {{(PIX_EXT_W - BITDEPTH){1'b0}}, rd_pix};
    assign rd_word = word_sel(pix_ext, cnt_dc);
    // Equality stop on {last, DC_MAX}: the counter never has to step past
    // column N_COLS-1, so no extra width is needed.
    assign is_last = (cnt_col == head.last) && (cnt_dc == DC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ctrl_req <= 1'b0;
            ctrl_rel <= 1'b0;
            fb_wren  <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            cnt_col  <= '0;
            cnt_dc   <= '0;
        end else begin
            fb_wren  <= 1'b0;
            ctrl_rel <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (q_level != '0) begin
                        state    <= ST_REQ;
                        ctrl_req <= 1'b1;
                        cnt_col  <= head.first;
                        cnt_dc   <= '0;
                    end
                end
                ST_REQ, ST_RUN: begin
                    if (state == ST_RUN || ctrl_gnt) begin
                        ctrl_req <= 1'b0;
                        fb_wren  <= 1'b1;
                        fb_addr  <= fb_pack(head.row, cnt_col, head.bank, cnt_dc);
                        fb_data  <= rd_word;
                        if (cnt_dc == DC_MAX) begin
                            cnt_dc  <= '0;
                            cnt_col <= cnt_col + 1'b1;
                        end else begin
                            cnt_dc <= cnt_dc + 1'b1;
                        end
                        if (is_last) begin
                            state    <= ST_FLUSH;
                            ctrl_rel <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else if (wr_row_store && !store_ok) begin
            wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hub75_fb_writein_ring.sv
// Directed bench for hub75_fb_writein_ring: fills rows with known pixel
// patterns, commits spans, grants the arbiter and checks every FB write.
module tb_hub75_fb_writein_ring;
    import hub75_fb_writein_ring_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LOG_N_BANKS-1:0] wr_bank_addr;
    logic [LOG_N_ROWS-1:0]  wr_row_addr;
    logic [LOG_N_COLS-1:0]  wr_col_first;
    logic [LOG_N_COLS-1:0]  wr_col_last;
    logic                   wr_row_store;
    logic                   wr_row_rdy;
    logic [BITDEPTH-1:0]    wr_data;
    logic [LOG_N_COLS-1:0]  wr_col_addr;
    logic                   wr_en;
    logic                   wr_err;
    logic [LOG_N_LBUF:0]    q_level;
    logic                   ctrl_req;
    logic                   ctrl_gnt;
    logic                   ctrl_rel;
    logic [FB_AW-1:0]       fb_addr;
    logic [FB_DW-1:0]       fb_data;
    logic                   fb_wren;

    int n_tests = 0;
    int n_fail  = 0;

    hub75_fb_writein_ring dut (
        .clk          (clk),
        .rst          (rst),
        .wr_bank_addr (wr_bank_addr),
        .wr_row_addr  (wr_row_addr),
        .wr_col_first (wr_col_first),
        .wr_col_last  (wr_col_last),
        .wr_row_store (wr_row_store),
        .wr_row_rdy   (wr_row_rdy),
        .wr_data      (wr_data),
        .wr_col_addr  (wr_col_addr),
        .wr_en        (wr_en),
        .wr_err       (wr_err),
        .q_level      (q_level),
        .ctrl_req     (ctrl_req),
        .ctrl_gnt     (ctrl_gnt),
        .ctrl_rel     (ctrl_rel),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_wren      (fb_wren)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int seed, input int c);
        return 24'(c * 32'h010101) ^ 24'(seed);
    endfunction

    // FB address layout {row[4:0], col[5:0], bank, dc}
    function automatic logic [31:0] exp_addr(input int row, input int col, input int bank, input int d);
        return 32'((row << 8) | (col << 2) | (bank << 1) | d);
    endfunction

    function automatic logic [31:0] exp_word(input int seed, input int c, input int d);
        logic [31:0] p;
        p = {8'h00, pix(seed, c)};
        return (d != 0) ? {16'h0, p[31:16]} : {16'h0, p[15:0]};
    endfunction

    task automatic fill(input int seed);
        for (int c = 0; c < N_COLS; c++) begin
            wr_en       = 1'b1;
            wr_col_addr = 6'(c);
            wr_data     = pix(seed, c);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic store(input int bank, input int row, input int first, input int last);
        wr_bank_addr = 1'(bank);
        wr_row_addr  = 5'(row);
        wr_col_first = 6'(first);
        wr_col_last  = 6'(last);
        wr_row_store = 1'b1;
        @(negedge clk);
        wr_row_store = 1'b0;
    endtask

    // Waits for ctrl_req, grants after gdly cycles and checks every write.
    // store_on_rel raises wr_row_store in the ctrl_rel cycle (fields preset by caller);
    // abort_at >= 0 asserts rst in the cycle of that write index and returns.
    task automatic drain_check(input string tag, input int bank, input int row, input int first,
                               input int last, input int seed, input int gdly,
                               input bit store_on_rel, input int abort_at);
        int k;
        int nw;
        int c;
        int d;
        k = 0;
        while (ctrl_req !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/req"}, 32'(ctrl_req), 1);
        repeat (gdly) @(negedge clk);
        chk({tag, "/req_held"}, 32'(ctrl_req), 1);
        chk({tag, "/no_wr_before_gnt"}, 32'(fb_wren), 0);
        ctrl_gnt = 1'b1;
        @(negedge clk);
        ctrl_gnt = 1'b0;
        chk({tag, "/req_drop"}, 32'(ctrl_req), 0);
        nw = (last - first + 1) * FB_DC;
        for (int i = 0; i < nw; i++) begin
            c = first + i / FB_DC;
            d = i % FB_DC;
            chk({tag, "/wren"}, 32'(fb_wren), 1);
            chk({tag, "/addr"}, 32'(fb_addr), exp_addr(row, c, bank, d));
            chk({tag, "/data"}, 32'(fb_data), exp_word(seed, c, d));
            chk({tag, "/rel"}, 32'(ctrl_rel), (i == nw - 1) ? 1 : 0);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "/rst_wren"}, 32'(fb_wren), 0);
                chk({tag, "/rst_rel"}, 32'(ctrl_rel), 0);
                chk({tag, "/rst_req"}, 32'(ctrl_req), 0);
                return;
            end
            if (store_on_rel && i == nw - 1) wr_row_store = 1'b1;
            @(negedge clk);
            wr_row_store = 1'b0;
        end
        chk({tag, "/end_wren"}, 32'(fb_wren), 0);
        chk({tag, "/end_rel"}, 32'(ctrl_rel), 0);
    endtask

    initial begin
        rst          = 1'b1;
        wr_bank_addr = '0;
        wr_row_addr  = '0;
        wr_col_first = '0;
        wr_col_last  = '0;
        wr_row_store = 1'b0;
        wr_data      = '0;
        wr_col_addr  = '0;
        wr_en        = 1'b0;
        ctrl_gnt     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/rdy",   32'(wr_row_rdy), 1);
        chk("rst/err",   32'(wr_err), 0);
        chk("rst/level", 32'(q_level), 0);
        chk("rst/req",   32'(ctrl_req), 0);
        chk("rst/rel",   32'(ctrl_rel), 0);
        chk("rst/wren",  32'(fb_wren), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full row, bank1 row5, cols 0..63, grant three cycles after request
        fill(0);
        store(1, 5, 0, 63);
        chk("t1/level", 32'(q_level), 1);
        drain_check("t1", 1, 5, 0, 63, 0, 3, 1'b0, -1);
        chk("t1/level_after", 32'(q_level), 0);

        // Partial span 10..12
        fill(32'h5A5A5A);
        store(0, 7, 10, 12);
        drain_check("t2", 0, 7, 10, 12, 32'h5A5A5A, 0, 1'b0, -1);
        chk("t2/level_after", 32'(q_level), 0);

        // Bad span first > last
        store(0, 3, 20, 19);
        chk("t5/err", 32'(wr_err), 1);
        chk("t5/level", 32'(q_level), 0);
        repeat (3) @(negedge clk);
        chk("t5/no_req", 32'(ctrl_req), 0);
        chk("t5/level_late", 32'(q_level), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5/err_cleared", 32'(wr_err), 0);

        // Ring fill with no grant
        fill(32'h100000); store(0, 1, 0, 3);
        fill(32'h200000); store(1, 2, 4, 5);
        fill(32'h300000); store(0, 3, 60, 63);
        fill(32'h400000); store(1, 31, 62, 63);
        chk("t3/level_full", 32'(q_level), 4);
        chk("t3/rdy_full", 32'(wr_row_rdy), 0);
        chk("t3/req_pending", 32'(ctrl_req), 1);
        chk("t3/no_wren", 32'(fb_wren), 0);
        wr_en       = 1'b1;
        wr_col_addr = 6'd0;
        wr_data     = 24'hFFFFFF;
        @(negedge clk);
        wr_en = 1'b0;
        store(0, 9, 0, 0);
        chk("t3/err", 32'(wr_err), 1);
        chk("t3/level_still", 32'(q_level), 4);
        drain_check("t3a", 0, 1, 0, 3, 32'h100000, 2, 1'b0, -1);
        chk("t3/level_3", 32'(q_level), 3);
        chk("t3/rdy_back", 32'(wr_row_rdy), 1);
        drain_check("t3b", 1, 2, 4, 5, 32'h200000, 0, 1'b0, -1);
        drain_check("t3c", 0, 3, 60, 63, 32'h300000, 1, 1'b0, -1);
        drain_check("t3d", 1, 31, 62, 63, 32'h400000, 0, 1'b0, -1);
        chk("t3/level_empty", 32'(q_level), 0);

        // Store in the ctrl_rel cycle with two rows queued
        fill(32'h0A0000); store(1, 10, 0, 1);
        fill(32'h0B0000); store(0, 11, 2, 3);
        chk("t4/level_2", 32'(q_level), 2);
        fill(32'h0C0000);
        wr_bank_addr = 1'b1;
        wr_row_addr  = 5'd12;
        wr_col_first = 6'd63;
        wr_col_last  = 6'd63;
        drain_check("t4a", 1, 10, 0, 1, 32'h0A0000, 0, 1'b1, -1);
        chk("t4/level_kept", 32'(q_level), 2);
        chk("t4/rdy", 32'(wr_row_rdy), 1);
        drain_check("t4b", 0, 11, 2, 3, 32'h0B0000, 0, 1'b0, -1);
        drain_check("t4c", 1, 12, 63, 63, 32'h0C0000, 0, 1'b0, -1);
        chk("t4/level_empty", 32'(q_level), 0);

        // Reset at write 40 of 128, then a normal drain
        fill(32'h00F00F);
        store(1, 5, 0, 63);
        drain_check("t6", 1, 5, 0, 63, 32'h00F00F, 1, 1'b0, 39);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6/level", 32'(q_level), 0);
        chk("t6/rdy", 32'(wr_row_rdy), 1);
        chk("t6/err", 32'(wr_err), 0);
        chk("t6/req", 32'(ctrl_req), 0);
        chk("t6/wren", 32'(fb_wren), 0);
        fill(32'h777777);
        store(0, 8, 5, 6);
        drain_check("t6b", 0, 8, 5, 6, 32'h777777, 2, 1'b0, -1);
        chk("t6/level_end", 32'(q_level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
